mac_neuron: RTL

Single-neuron multiply-accumulate engine that produces the pre-activation value consumed by the `sigmoid` lookup block. It accepts a stream of N signed 8.8 input/weight pairs and accumulates their products at full precision. It then adds a bias, rounds to 8.8 and hands the result to `sigmoid` over the `done`/`sig_in` → `sig_ready`/`sig_out` handshake. Finally it captures the activation and presents it downstream.

---
 rtl/mac_neuron.sv | 117 +++++++++++
 1 files changed

// File: rtl/mac_neuron.sv
// Single-neuron MAC: accumulates N 8.8 products, adds bias, rounds, hands off to sigmoid.
// Optional MAC_SATURATE_EN clamps the rounded pre-activation to the 8.8 range.
module mac_neuron #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [15:0] in_weight,
    output logic        in_ready,
    output logic        done,
    output logic [15:0] sig_in,
    input  logic        sig_ready,
    input  logic [15:0] sig_out,
    output logic [15:0] act_out,
    output logic        act_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, WAIT_SIG} state_t;

    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
    localparam logic signed [ACC_W-9:0] T_MAX = 32767;
    localparam logic signed [ACC_W-9:0] T_MIN = -32768;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic signed [ACC_W-1:0]  acc;
    logic [15:0]              bias_q;

    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-9:0]  t;
    logic [15:0]              t16;
    logic                     unused_low;

    assign prod     = $signed(in_data) * $signed(in_weight);
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W-24){bias_q[15]}}, bias_q, 8'h00};
    // Adding half an LSB before the shift gives round-half-up
    assign sum      = acc + bias_ext + ACC_W'(128);
    assign t        = sum[ACC_W-1:8];
    assign unused_low = ^sum[7:0];

`ifdef MAC_SATURATE_EN
    always_comb begin
        t16 = t[15:0];
        unique case (1'b1)
            (t > T_MAX): t16 = 16'h7fff;
            (t < T_MIN): t16 = 16'h8000;
            default: ;
        endcase
    end
`else
    logic unused_hi;
    assign t16       = t[15:0];
    assign unused_hi = ^{t[ACC_W-9:16], T_MAX, T_MIN};
`endif

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            bias_q    <= '0;
            done      <= 1'b0;
            sig_in    <= '0;
            act_out   <= '0;
            act_valid <= 1'b0;
        end else begin
            done      <= 1'b0;
            act_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_q <= bias;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) state <= FINAL;
                    end
                end
                FINAL: begin
                    sig_in <= t16;
                    done   <= 1'b1;
                    state  <= WAIT_SIG;
                end
                WAIT_SIG: begin
                    // sigmoid cannot answer in the same cycle it sees done
                    if (sig_ready && !done) begin
                        act_out   <= sig_out;
                        act_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
